count_seq_ctrl: RTL
===================

# count_seq_ctrl

Sequencing controller for the 32-bit counter datapath: the free-running count register, its combinational doubled value, and its even-value hold register. It adds start/stop/limit control and a done pulse, and replaces the inferred even-value latch with an enabled flip-flop. The block sits between a host control interface and the counter, and it is the unit formal properties are written against.

## Interface
- WIDTH, 32, width of count, limit and derived outputs
- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run; acted on only in IDLE
- stop  in  1  abort a run; acted on only in RUN
- limit  in  WIDTH  terminal count; sampled only on an accepted start
- step_en  in  1  advance count by one; acted on only in RUN
- count  out  WIDTH  current count register
- dbl  out  WIDTH  combinational, count*2 truncated to WIDTH
- even_hold  out  WIDTH  most recent even value loaded into count
- busy  out  1  high exactly while in RUN
- done  out  1  one-cycle pulse while in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- rst_n low at a clock edge sets the following, regardless of state:
  - state to IDLE
  - count, limit_q and even_hold to 0
  - busy and done low
- IDLE:
  - start=1 and stop=0: count<=0, even_hold<=0, limit_q<=limit.
    - If limit==0, go to DONE.
    - Otherwise go to RUN.
  - start and stop both high: stop wins; stay in IDLE, no registers change.
- RUN:
  - stop=1: go to IDLE; count and even_hold hold their values; step_en is ignored that cycle.
  - Otherwise, step_en=1: count<=count+1.
    - If count+1==limit_q, go to DONE.
  - start is ignored.
- DONE: done=1 for one cycle, then go to IDLE unconditionally. start and stop are ignored.
- even_hold: loads the same value as count on every count load whose value has bit 0 == 0, including the load of 0 on start. Otherwise it holds. It is a flop with enable; no latches anywhere in the block.
- Arithmetic:
  - Increment is modulo 2^WIDTH.
  - dbl discards the carry out.
  - count never exceeds limit_q, so count does not wrap in legal operation. count wrapping is a property violation.
- Required invariants (immediate asserts):
  - dbl[0]==0
  - even_hold[0]==0
  - busy implies count<limit_q
  - done implies count==limit_q
  - busy and done are never high together

## Timing
- start accepted at edge N: busy=1 and count=0 visible after edge N.
- Each step_en=1 sampled in RUN: count increments one cycle later.
- Terminal step at edge N: count==limit_q and done=1 after edge N; busy=0 after edge N; state is IDLE after edge N+1.
- limit==0: done pulses in the cycle after start; busy never rises.
- Minimum run with limit=L and step_en held high: start at edge N, done after edge N+L.
- stop at edge N: busy=0 after edge N; no done pulse.
- A start presented in the cycle done is high is ignored. Earliest accepted restart is the cycle after done.
- rst_n low mid-run: all outputs are 0 after that edge; no done pulse.

## Structure
- Package count_seq_ctrl_pkg contains:
  - the state enum (IDLE, RUN, DONE)
  - the default WIDTH localparam
- Optional sub-module count_seq_dp holds count, even_hold and dbl, with load/inc enables driven by the FSM. Keep the FSM and invariant asserts in the top.

## Test plan
- Reset then start with limit=5, step_en held 1 -> count steps 0,1,2,3,4,5; done pulses when count=5; even_hold takes the values 0,0,2,2,4,4.
- limit=0 start -> done high in the next cycle, busy stays 0, count=0.
- limit=10, step_en toggled 1,0,1,0 -> count increments only on cycles where step_en=1; after 4 cycles count=2.
- Run with limit=8; stop asserted when count=3 -> busy=0 next cycle, count holds 3, even_hold holds 2, no done; restart -> count=0.
- start and stop asserted together in IDLE -> stays in IDLE, busy=0, count unchanged.
- rst_n low when count=6 in RUN -> next cycle count=0, even_hold=0, busy=0, done=0, state IDLE; every invariant assert holds throughout all scenarios.

Source files
------------

// File: rtl/count_seq_ctrl_pkg.sv
// rtl/count_seq_ctrl_pkg.sv - shared types and defaults for the count sequencing controller
// Contents: state_e (IDLE/RUN/DONE) and the default datapath width COUNT_WIDTH.
package count_seq_ctrl_pkg;

  localparam int COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/count_seq_dp.sv
// rtl/count_seq_dp.sv - count register, even-value hold flop and doubled value
// Ports: clk, rst_n (sync, active-low); clr loads count with 0; inc adds one to count;
//        count, even_hold, dbl outputs, all WIDTH bits wide.
module count_seq_dp
  import count_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] even_hold,
  output logic [WIDTH-1:0] dbl
);

  logic [WIDTH-1:0] count_d, count_q;
  logic [WIDTH-1:0] even_hold_d, even_hold_q;
  logic             load;

  always_comb begin
    count_d     = count_q;
    even_hold_d = even_hold_q;
    load        = clr | inc;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
    // Enabled flop: capture only loads whose new value is even.
    if (load && !count_d[0]) begin
      even_hold_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      even_hold_q <= '0;
    end else begin
      count_q     <= count_d;
      even_hold_q <= even_hold_d;
    end
  end

  assign count     = count_q;
  assign even_hold = even_hold_q;
  // Shift left drops the carry out of the top bit.
  assign dbl       = {count_q[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - start/stop/limit sequencing FSM around the counter datapath
// Ports: clk, rst_n (sync, active-low); start, stop, step_en controls; limit terminal count;
//        count, dbl, even_hold datapath outputs; busy (in RUN), done (one-cycle pulse).
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             step_en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] dbl,
  output logic [WIDTH-1:0] even_hold,
  output logic             busy,
  output logic             done
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] limit_d, limit_q;
  logic             clr, inc;
  logic [WIDTH-1:0] count_nxt;

  assign count_nxt = count + WIDTH'(1);

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        // stop wins over a simultaneous start.
        if (start && !stop) begin
          clr     = 1'b1;
          limit_d = limit;
          state_d = (limit == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (step_en) begin
          inc = 1'b1;
          if (count_nxt == limit_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  count_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (inc),
    .count    (count),
    .even_hold(even_hold),
    .dbl      (dbl)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (dbl[0] == 1'b0);
      assert (even_hold[0] == 1'b0);
      assert (!busy || (count < limit_q));
      assert (!done || (count == limit_q));
      assert (!(busy && done));
      assert (!(inc && (count == '1)));
    end
  end

endmodule
